// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch front-end.
//   XLEN          : address/PC width
//   ILEN          : instruction word width
//   INSTR_NOP     : canonical NOP (addi x0,x0,0) shown to decode during reset
//   fetch_entry_t : one prefetch FIFO record {instruction, pc}
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t records.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   push, din       : write request and the record to store
//   pop, dout       : read request and the record at the head
//   flush           : discard all entries; wins over a same-cycle push
//   full, empty     : occupancy flags
//   count           : number of valid entries (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output fetch_entry_t             dout,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. Pointers are exactly AW bits so
    // they wrap on their own at DEPTH; count carries the extra bit needed
    // to tell full from empty. A flush simply rewinds everything, which is
    // why it overrides any push arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage array. It needs no reset because nothing is read from a slot
    // until count says it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Fetch front-end: owns the fetch PC, issues word requests to a synchronous
// instruction memory (data back one cycle later), buffers the returned
// words in a prefetch FIFO and presents {instruction, pc} to decode over a
// valid/ready handshake. A redirect from execute flushes and refetches.
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   iaddr, imem_req            : memory request address (word-aligned) and valid
//   idata                      : memory data for last cycle's request
//   redirect_valid/redirect_pc : taken branch/jump and its target
//   dec_valid, dec_ready       : decode handshake
//   dec_instr, pc              : instruction and PC at the FIFO head
module instr_fetch_queue #(
    parameter int               DEPTH    = 4,
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [XLEN-1:0]  iaddr,
    output logic             imem_req,
    input  logic [31:0]      idata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [31:0]      dec_instr,
    output logic [XLEN-1:0]  pc
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ~XLEN'(3);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    fetch_entry_t    last_entry;

    // Buffered entries plus the one response still on its way must fit in
    // the FIFO, otherwise a returning word would have nowhere to land.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign imem_req   = !reset && !redirect_valid && !fifo_full
                        && (occupancy < (CW+1)'(DEPTH));
    assign iaddr      = fpc;
    assign dec_valid  = !reset && !fifo_empty;
    assign fifo_pop   = dec_valid && dec_ready;
    assign push_entry = '{instr: idata, pc: req_pc};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .flush (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fetch PC. A redirect overrides sequential advance, and back-to-back
    // redirects naturally let the latest target stand. Low address bits are
    // cleared so requests are always word-aligned; the +4 wraps at 2^XLEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            fpc <= redirect_pc & ~XLEN'(3);
        end else if (imem_req) begin
            fpc <= fpc + XLEN'(4);
        end
    end

    // Response tracking. inflight marks that idata this cycle belongs to a
    // request, and req_pc remembers which address it was. A redirect drops
    // imem_req, so nothing is marked in flight past the flush, and the
    // response landing in the redirect cycle itself is discarded by the
    // FIFO flush taking priority over the push.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            req_pc   <= RESET_PC_ALIGNED;
        end else begin
            inflight <= imem_req;
            req_pc   <= fpc;
        end
    end

    // Copy of the most recently delivered entry so the decode outputs keep
    // their last value while the FIFO is empty instead of showing whatever
    // stale slot the read pointer now points at.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_entry <= '{instr: INSTR_NOP, pc: RESET_PC_ALIGNED};
        end else if (fifo_pop) begin
            last_entry <= head;
        end
    end

    // Decode-facing data: a NOP at the reset PC while in reset, the live
    // head when something is buffered, otherwise the last delivered entry.
    always_comb begin
        dec_instr = INSTR_NOP;
        pc        = RESET_PC_ALIGNED;
        if (!reset) begin
            if (fifo_empty) begin
                dec_instr = last_entry.instr;
                pc        = last_entry.pc;
            end else begin
                dec_instr = head.instr;
                pc        = head.pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
// Directed, table-driven bench for instr_fetch_queue. The memory model
// returns the requested address as the instruction word, so every delivered
// dec_instr must equal its pc. A second instance with RESET_PC near the top
// of the address space covers fetch PC wrap-around.
module tb_instr_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iaddr;
    logic        imem_req;
    logic [31:0] idata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] pc;

    logic [31:0] iaddr2;
    logic        imem_req2;
    logic [31:0] idata2 = 32'h0;
    logic        dec_valid2;
    logic [31:0] dec_instr2;
    logic [31:0] pc2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk_addr;
        logic        e_dv;
        logic        chk_dec;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .iaddr          (iaddr),
        .imem_req       (imem_req),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .pc             (pc)
    );

    instr_fetch_queue #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut2 (
        .clk            (clk),
        .reset          (reset),
        .iaddr          (iaddr2),
        .imem_req       (imem_req2),
        .idata          (idata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .dec_valid      (dec_valid2),
        .dec_ready      (1'b1),
        .dec_instr      (dec_instr2),
        .pc             (pc2)
    );

    // Synchronous instruction memory: the word returned is the address that
    // was presented in the previous cycle.
    always @(posedge clk) begin
        idata  <= iaddr;
        idata2 <= iaddr2;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic rst, input logic rv,
                                input logic [31:0] rpc, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic chk_addr, input logic dv,
                                input logic chk_dec, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.name = name;     v.rst = rst;         v.rv = rv;       v.rpc = rpc;
        v.rdy = rdy;       v.e_req = req;       v.e_addr = addr; v.chk_addr = chk_addr;
        v.e_dv = dv;       v.chk_dec = chk_dec; v.e_pc = epc;    v.e_instr = einstr;
        vecs.push_back(v);
    endfunction

    // Normal running cycle; when valid, the instruction equals its pc.
    function automatic void addRun(input string name, input logic rdy, input logic req,
                                   input logic [31:0] addr, input logic dv,
                                   input logic [31:0] epc);
        add(name, 1'b0, 1'b0, 32'h0, rdy, req, addr, 1'b1, dv, dv, epc, epc);
    endfunction

    function automatic void addRedirect(input string name, input logic [31:0] rpc,
                                        input logic rdy, input logic [31:0] addr,
                                        input logic dv, input logic [31:0] epc);
        add(name, 1'b0, 1'b1, rpc, rdy, 1'b0, addr, 1'b1, dv, dv, epc, epc);
    endfunction

    function automatic void addReset(input string name, input logic rdy, input logic chk_addr);
        add(name, 1'b1, 1'b0, 32'h0, rdy, 1'b0, 32'h0, chk_addr, 1'b0, 1'b1, 32'h0, NOP);
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        dec_ready      = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v);
        check32({v.name, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.e_req});
        check32({v.name, ".dec_valid"}, {31'b0, dec_valid}, {31'b0, v.e_dv});
        if (v.chk_addr) begin
            check32({v.name, ".iaddr"}, iaddr, v.e_addr);
        end
        if (v.chk_dec) begin
            check32({v.name, ".pc"}, pc, v.e_pc);
            check32({v.name, ".dec_instr"}, dec_instr, v.e_instr);
        end
    endtask

    initial begin
        // Reset, then streaming with decode always ready.
        addReset("rst0a", 1'b1, 1'b1);
        addReset("rst0b", 1'b1, 1'b1);
        add("s1c0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, NOP);
        addRun("s1c1", 1'b1, 1'b1, 32'h4,  1'b0, 32'h0);
        addRun("s1c2", 1'b1, 1'b1, 32'h8,  1'b1, 32'h0);
        addRun("s1c3", 1'b1, 1'b1, 32'hC,  1'b1, 32'h4);
        addRun("s1c4", 1'b1, 1'b1, 32'h10, 1'b1, 32'h8);

        // Reset mid-stream, then back-pressure until the FIFO fills.
        addReset("rst1a", 1'b0, 1'b0);
        addReset("rst1b", 1'b0, 1'b1);
        addRun("s2d0", 1'b0, 1'b1, 32'h0,  1'b0, 32'h0);
        addRun("s2d1", 1'b0, 1'b1, 32'h4,  1'b0, 32'h0);
        addRun("s2d2", 1'b0, 1'b1, 32'h8,  1'b1, 32'h0);
        addRun("s2d3", 1'b0, 1'b1, 32'hC,  1'b1, 32'h0);
        addRun("s2d4", 1'b0, 1'b0, 32'h10, 1'b1, 32'h0);
        for (int i = 5; i < 10; i++) begin
            addRun($sformatf("s2d%0d", i), 1'b0, 1'b0, 32'h10, 1'b1, 32'h0);
        end
        addRun("s2e0", 1'b1, 1'b0, 32'h10, 1'b1, 32'h0);
        addRun("s2e1", 1'b1, 1'b1, 32'h10, 1'b1, 32'h4);
        addRun("s2e2", 1'b1, 1'b1, 32'h14, 1'b1, 32'h8);
        addRun("s2e3", 1'b1, 1'b1, 32'h18, 1'b1, 32'hC);
        addRun("s2e4", 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);

        // Redirect with three buffered entries and one response in flight.
        addReset("rst2a", 1'b0, 1'b0);
        addReset("rst2b", 1'b0, 1'b1);
        addRun("s3d0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        addRun("s3d1", 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        addRun("s3d2", 1'b0, 1'b1, 32'h8, 1'b1, 32'h0);
        addRun("s3d3", 1'b0, 1'b1, 32'hC, 1'b1, 32'h0);
        addRedirect("s3R", 32'h0000_0103, 1'b0, 32'h10, 1'b1, 32'h0);
        addRun("s3R1", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        addRun("s3R2", 1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
        addRun("s3R3", 1'b1, 1'b1, 32'h108, 1'b1, 32'h100);
        addRun("s3R4", 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104);

        // Fill the FIFO behind a stalled decode, then reset while full.
        addRun("s4h0", 1'b0, 1'b1, 32'h110, 1'b1, 32'h108);
        addRun("s4h1", 1'b0, 1'b1, 32'h114, 1'b1, 32'h108);
        addRun("s4h2", 1'b0, 1'b0, 32'h118, 1'b1, 32'h108);
        addRun("s4h3", 1'b0, 1'b0, 32'h118, 1'b1, 32'h108);
        addReset("rst3a", 1'b0, 1'b0);
        addReset("rst3b", 1'b1, 1'b1);
        add("s4c0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, NOP);
        addRun("s4c1", 1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
        addRun("s4c2", 1'b1, 1'b1, 32'h8, 1'b1, 32'h0);

        // Redirect coinciding with a handshake, then two redirects in a row.
        addReset("rst4a", 1'b1, 1'b0);
        addReset("rst4b", 1'b1, 1'b1);
        addRun("s5f0", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        addRun("s5f1", 1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
        addRun("s5f2", 1'b1, 1'b1, 32'h8, 1'b1, 32'h0);
        addRun("s5f3", 1'b1, 1'b1, 32'hC, 1'b1, 32'h4);
        addRedirect("s5f4", 32'h0000_0200, 1'b1, 32'h10, 1'b1, 32'h8);
        addRun("s5f5", 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        addRun("s5f6", 1'b1, 1'b1, 32'h204, 1'b0, 32'h0);
        addRun("s5f7", 1'b1, 1'b1, 32'h208, 1'b1, 32'h200);
        addRedirect("s5f8", 32'h0000_0300, 1'b1, 32'h20C, 1'b1, 32'h204);
        addRedirect("s5f9", 32'h0000_0401, 1'b1, 32'h300, 1'b0, 32'h0);
        addRun("s5f10", 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
        addRun("s5f11", 1'b1, 1'b1, 32'h404, 1'b0, 32'h0);
        addRun("s5f12", 1'b1, 1'b1, 32'h408, 1'b1, 32'h400);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i]);
        end

        // Wrap-around instance: fetch and delivery cross 32'hFFFF_FFFC -> 0.
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        #1;
        check32("wrap.rst.imem_req", {31'b0, imem_req2}, 32'h0);
        check32("wrap.rst.dec_valid", {31'b0, dec_valid2}, 32'h0);
        check32("wrap.rst.pc", pc2, 32'hFFFF_FFF8);
        check32("wrap.rst.dec_instr", dec_instr2, NOP);
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            check32($sformatf("wrap.c%0d.imem_req", c), {31'b0, imem_req2}, 32'h1);
            check32($sformatf("wrap.c%0d.iaddr", c), iaddr2, 32'hFFFF_FFF8 + 32'(4 * c));
            check32($sformatf("wrap.c%0d.dec_valid", c), {31'b0, dec_valid2},
                    (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) begin
                check32($sformatf("wrap.c%0d.pc", c), pc2, 32'hFFFF_FFF8 + 32'(4 * (c - 2)));
                check32($sformatf("wrap.c%0d.dec_instr", c), dec_instr2,
                        32'hFFFF_FFF8 + 32'(4 * (c - 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
